// File: rtl/vx_burst_rr_arbiter.sv
// vx_burst_rr_arbiter: round-robin arbiter with stall lock and MAX_BURST owner retention.
// Define VX_ARB_PERF_EN to implement the transfer/stall perf counters.
module vx_burst_rr_arbiter #(
    parameter int NUM_REQS     = 4,
    parameter int MAX_BURST    = 1,
    parameter int LOG_NUM_REQS = $clog2(NUM_REQS)
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [NUM_REQS-1:0]                                requests,
    input  logic                                               enable,
    output logic [((LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1)-1:0] grant_index,
    output logic [NUM_REQS-1:0]                                grant_onehot,
    output logic                                               grant_valid,
    output logic [31:0]                                        perf_xfer_count,
    output logic [31:0]                                        perf_stall_count
);
    localparam int IW = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW:0] BURST_LAST = (BW+1)'(MAX_BURST);

    typedef enum logic {ARB, HOLD} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
    logic [BW-1:0] burst_q, burst_d, burst_base;
    logic [BW:0]   burst_inc;
    logic          hold, found, xfer, stall;
    int            start;

    function automatic logic req_at(input logic [NUM_REQS-1:0] r, input int k);
        logic [NUM_REQS-1:0] s;
        s = r >> k;
        return s[0];
    endfunction

    always_comb begin
        hold = state_q == HOLD && req_at(requests, int'(owner_q));
        // a released lock searches from just past the old owner
        start = (state_q == HOLD) ? (int'(owner_q) + 1) % NUM_REQS : int'(rr_ptr_q);
        found = 1'b0;
        win = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!found && req_at(requests, (start + i) % NUM_REQS)) begin
                found = 1'b1;
                win = IW'((start + i) % NUM_REQS);
            end
        end
        grant_valid = !reset && (hold || found);
        grant_index = reset ? '0 : (hold ? owner_q : win);
        grant_onehot = grant_valid ? NUM_REQS'(1) << grant_index : '0;
        burst_base = (state_q == HOLD && !hold) ? '0 : burst_q;
        burst_inc = {1'b0, burst_base} + (BW+1)'(1);
        stall = grant_valid && !enable;
        xfer = grant_valid && enable;
        state_d = ARB;
        owner_d = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d = burst_base;
        if (stall) begin
            state_d = HOLD;
            owner_d = grant_index;
        end else if (xfer && burst_inc < BURST_LAST) begin
            state_d = HOLD;
            owner_d = grant_index;
            burst_d = burst_inc[BW-1:0];
        end else if (xfer) begin
            rr_ptr_d = IW'((int'(grant_index) + 1) % NUM_REQS);
            burst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

`ifdef VX_ARB_PERF_EN
    logic [31:0] xfer_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (xfer) xfer_cnt_q <= xfer_cnt_q + 32'd1;
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_xfer_count  = xfer_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`else
    assign perf_xfer_count  = '0;
    assign perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_vx_burst_rr_arbiter.sv
// tb_vx_burst_rr_arbiter: table-driven check of two arbiter instances (MAX_BURST 1 and 3).
module tb_vx_burst_rr_arbiter;
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       en;
        logic       v;
        logic [1:0] idx;
    } vec_t;

    typedef struct {
        bit         sel;
        int         num;
        logic       v;
        logic [1:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, en1, gv1, rst3, en3, gv3;
    logic [3:0]  req1, go1, req3, go3;
    logic [1:0]  gi1, gi3;
    logic [31:0] px1, ps1, px3, ps3;
    vec_t        tab1[$], tab3[$];
    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    vx_burst_rr_arbiter #(.NUM_REQS(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(rst1), .requests(req1), .enable(en1),
        .grant_index(gi1), .grant_onehot(go1), .grant_valid(gv1),
        .perf_xfer_count(px1), .perf_stall_count(ps1)
    );

    vx_burst_rr_arbiter #(.NUM_REQS(4), .MAX_BURST(3)) dut3 (
        .clk(clk), .reset(rst3), .requests(req3), .enable(en3),
        .grant_index(gi3), .grant_onehot(go3), .grant_valid(gv3),
        .perf_xfer_count(px3), .perf_stall_count(ps3)
    );

    function automatic vec_t mk(input bit r, input logic [3:0] q, input bit e, input bit v, input int i);
        vec_t t;
        t.rst = r;
        t.req = q;
        t.en = e;
        t.v = v;
        t.idx = 2'(i);
        return t;
    endfunction

    task automatic check_out();
        exp_t       e;
        logic       gv;
        logic [1:0] gi;
        logic [3:0] go, exp_oh;
        e = sb.pop_front();
        gv = e.sel ? gv3 : gv1;
        gi = e.sel ? gi3 : gi1;
        go = e.sel ? go3 : go1;
        exp_oh = e.v ? (4'b0001 << e.idx) : 4'b0000;
        vectors++;
        if (gv !== e.v || (e.v && gi !== e.idx) || go !== exp_oh) begin
            miscompares++;
            $display("FAIL mb%0d_vec%0d: valid=%b index=%0d onehot=%b, required valid=%b index=%0d onehot=%b",
                     e.sel ? 3 : 1, e.num, gv, gi, go, e.v, e.idx, exp_oh);
        end
    endtask

    task automatic apply(input bit sel, input int num, input vec_t t);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel) begin
            rst3 = t.rst; req3 = t.req; en3 = t.en;
        end else begin
            rst1 = t.rst; req1 = t.req; en1 = t.en;
        end
        e.sel = sel;
        e.num = num;
        e.v = t.v;
        e.idx = t.idx;
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    task automatic check_perf(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        rst1 = 1'b1; req1 = '0; en1 = 1'b0;
        rst3 = 1'b1; req3 = '0; en3 = 1'b0;
        // rotation
        tab1.push_back(mk(1, 4'b1111, 1, 0, 0));
        for (int k = 0; k < 8; k++) tab1.push_back(mk(0, 4'b1111, 1, 1, k % 4));
        // stall lock, then drain
        repeat (3) tab1.push_back(mk(0, 4'b0110, 0, 1, 1));
        tab1.push_back(mk(0, 4'b0111, 0, 1, 1));
        tab1.push_back(mk(0, 4'b0111, 1, 1, 1));
        tab1.push_back(mk(0, 4'b0111, 1, 1, 2));
        tab1.push_back(mk(0, 4'b0111, 1, 1, 0));
        // lock release
        tab1.push_back(mk(0, 4'b0100, 0, 1, 2));
        tab1.push_back(mk(0, 4'b1001, 0, 1, 3));
        tab1.push_back(mk(0, 4'b1001, 1, 1, 3));
        tab1.push_back(mk(0, 4'b1001, 1, 1, 0));
        // withdrawal while stalled does not advance the pointer
        tab1.push_back(mk(0, 4'b0100, 0, 1, 2));
        tab1.push_back(mk(0, 4'b0000, 1, 0, 0));
        tab1.push_back(mk(0, 4'b1111, 1, 1, 1));
        // reset mid-HOLD
        tab1.push_back(mk(0, 4'b1000, 0, 1, 3));
        tab1.push_back(mk(1, 4'b1111, 0, 0, 0));
        tab1.push_back(mk(0, 4'b1111, 1, 1, 0));
        tab1.push_back(mk(0, 4'b1111, 1, 1, 1));
        // perf: 5 transfers, 2 stalls from a fresh reset
        tab1.push_back(mk(1, 4'b1111, 1, 0, 0));
        for (int k = 0; k < 3; k++) tab1.push_back(mk(0, 4'b1111, 1, 1, k));
        repeat (2) tab1.push_back(mk(0, 4'b0010, 0, 1, 1));
        tab1.push_back(mk(0, 4'b0010, 1, 1, 1));
        tab1.push_back(mk(0, 4'b1111, 1, 1, 2));
        tab1.push_back(mk(0, 4'b0000, 1, 0, 0));
        // burst retention with MAX_BURST=3
        tab3.push_back(mk(1, 4'b0011, 1, 0, 0));
        foreach (tab3[k]) begin end
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 1));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 1));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 1));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0010, 1, 1, 1));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 1));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 1));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 0, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 0));
        tab3.push_back(mk(0, 4'b0011, 1, 1, 1));
        repeat (2) @(posedge clk);
        for (int k = 0; k < tab1.size(); k++) apply(1'b0, k, tab1[k]);
`ifdef VX_ARB_PERF_EN
        check_perf("perf_xfer", px1, 32'd5);
        check_perf("perf_stall", ps1, 32'd2);
`else
        check_perf("perf_xfer", px1, 32'd0);
        check_perf("perf_stall", ps1, 32'd0);
`endif
        for (int k = 0; k < tab3.size(); k++) apply(1'b1, k, tab3[k]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
